frame_buffer_ctrl: RTL and testbench
====================================

FRAME_BUFFER_CTRL -- requirements
Module: frame_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 19, meaning pixel address width.
REQ-002 The block SHALL have parameter DATA_W, default 9, meaning pixel width (RGB 3-3-3).
REQ-003 The block SHALL have parameter PIXELS, default 307200, meaning pixels per frame (640x480).
REQ-004 The block SHALL have parameter CLEAR_COLOR, default 0, meaning the DATA_W value written by a clear.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have wr_valid (in, 1), wr_ready (out, 1), wr_addr (in, ADDR_W) and wr_data (in, DATA_W): the renderer write port.
REQ-008 The block SHALL have rd_addr (in, ADDR_W) and rd_data (out, DATA_W): the VGA scan-out read port.
REQ-009 The block SHALL have swap_req (in, 1): a one-cycle pulse meaning the renderer has finished its frame.
REQ-010 The block SHALL have vblank_start (in, 1): a one-cycle pulse at the start of vertical blanking.
REQ-011 The block SHALL have clear_on_swap (in, 1): a level, sampled at swap, meaning clear the new back buffer.
REQ-012 The block SHALL have ramN_addr (out, ADDR_W), ramN_wdata (out, DATA_W), ramN_we (out, 1) and ramN_rdata (in, DATA_W) for N = 0 and N = 1; each external RAM has 1-cycle read latency.
REQ-013 The block SHALL have front_sel (out, 1): index of the RAM being scanned out.
REQ-014 The block SHALL have swap_pending (out, 1), clearing (out, 1), swap_dropped (out, 1, pulse) and frame_count (out, 8).

Function
REQ-015 The front RAM SHALL see addr=rd_addr and we=0 every cycle.
REQ-016 rd_data SHALL equal the rdata of the RAM that was front in the previous cycle.
REQ-017 A write SHALL be accepted when wr_valid && wr_ready; that same cycle the back RAM SHALL get addr=wr_addr, wdata=wr_data and we=1.
REQ-018 Outside writes and clears, the back RAM SHALL have we=0 and addr=wr_addr.
REQ-019 The FSM SHALL have states IDLE, PENDING and CLEAR; wr_ready SHALL be 1 only in IDLE.
REQ-020 IDLE SHALL go to PENDING on swap_req; a vblank_start in the same cycle SHALL NOT swap, and the swap waits for the next vblank_start.
REQ-021 PENDING SHALL, on vblank_start, do all of the following the next cycle: invert front_sel, increment frame_count (255 wraps to 0), and enter CLEAR if clear_on_swap=1, else IDLE.
REQ-022 CLEAR SHALL write CLEAR_COLOR to the new back RAM at addresses 0..PIXELS-1, one per cycle in ascending order, with we=1.
REQ-023 CLEAR SHALL return to IDLE in the cycle after address PIXELS-1 is written, reset its counter to 0, and take exactly PIXELS cycles.
REQ-024 vblank_start SHALL be ignored in IDLE and CLEAR.
REQ-025 swap_req in PENDING or CLEAR SHALL be ignored and SHALL pulse swap_dropped for one cycle, delayed by one cycle.
REQ-026 swap_pending SHALL be 1 exactly in PENDING, and clearing SHALL be 1 exactly in CLEAR.
REQ-027 The block SHALL accept a write address of PIXELS or above while still driving it to the RAM unchanged; range checking is the renderer's job.

Reset
REQ-028 While reset=1 at a clock edge, the block SHALL set: state IDLE, front_sel 0, frame_count 0, clear counter 0, swap_pending 0, clearing 0, swap_dropped 0, ram0_we 0, ram1_we 0.
REQ-029 After that reset edge, wr_ready SHALL be 1 and rd_data SHALL track ram0.
REQ-030 A reset during PENDING or CLEAR SHALL abandon that operation with no swap, and the clear SHALL NOT resume.

Verification
REQ-031 The bench SHALL cover: after reset, write addr 5 data 0x1FF -> ram1_we=1, ram1_addr=5, ram0_we=0, front_sel=0.
REQ-032 The bench SHALL cover: swap_req, then vblank_start 10 cycles later with clear_on_swap=0 -> swap_pending high for 10 cycles, then front_sel=1, frame_count=1, wr_ready=1.
REQ-033 The bench SHALL cover: swap with clear_on_swap=1 and PIXELS=16 -> ram0 written with 0 at addresses 0..15 over 16 cycles, wr_ready=0 during clear, then IDLE.
REQ-034 The bench SHALL cover: swap_req and vblank_start in the same IDLE cycle -> no swap; the next vblank_start swaps.
REQ-035 The bench SHALL cover: swap_req during CLEAR -> swap_dropped pulse, front_sel unchanged; reset at clear address 7 -> front_sel=0, both we=0 and wr_ready=1 next cycle.
REQ-036 The bench SHALL cover: 256 swaps -> frame_count wraps to 0, and rd_data follows the front RAM with 1-cycle latency across each swap.

Source files
------------

// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: double-buffered frame store controller.
// One RAM (front) is scanned out by the VGA side while the renderer writes
// the other (back). A swap is requested by the renderer and applied at the
// next vertical blank. The new back buffer can optionally be cleared after
// the swap.
//
// Write handshake: a write transfers on a rising edge where wr_valid and
// wr_ready are both 1. wr_ready depends only on FSM state and never on
// wr_valid. The back RAM strobe is driven combinationally in that same cycle.
// While wr_ready is 0, wr_valid is ignored and the renderer must hold its
// request until it is accepted.
module frame_buffer_ctrl #(
  parameter int                ADDR_W      = 19,
  parameter int                DATA_W      = 9,
  parameter int                PIXELS      = 307200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  // renderer write port
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  // scan-out read port
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  // swap control
  input  logic              swap_req,
  input  logic              vblank_start,
  input  logic              clear_on_swap,
  // external RAM 0
  output logic [ADDR_W-1:0] ram0_addr,
  output logic [DATA_W-1:0] ram0_wdata,
  output logic              ram0_we,
  input  logic [DATA_W-1:0] ram0_rdata,
  // external RAM 1
  output logic [ADDR_W-1:0] ram1_addr,
  output logic [DATA_W-1:0] ram1_wdata,
  output logic              ram1_we,
  input  logic [DATA_W-1:0] ram1_rdata,
  // status
  output logic              front_sel,
  output logic              swap_pending,
  output logic              clearing,
  output logic              swap_dropped,
  output logic [7:0]        frame_count,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(PIXELS - 1);

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  // front_sel as it was one cycle ago; matches the RAM's 1-cycle read latency
  logic              prev_front;

  logic              wr_fire;
  logic              back_we;
  logic [ADDR_W-1:0] back_addr;
  logic [DATA_W-1:0] back_wdata;

  assign wr_ready  = (state == IDLE);
  assign wr_fire   = wr_valid && wr_ready;
  assign fsm_state = state;

  // Swap / clear sequencing with all status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      front_sel    <= 1'b0;
      frame_count  <= 8'd0;
      clr_cnt      <= '0;
      swap_pending <= 1'b0;
      clearing     <= 1'b0;
      swap_dropped <= 1'b0;
      prev_front   <= 1'b0;
    end else begin
      prev_front   <= front_sel;
      // a request that arrives while a swap is in progress is lost; flag it
      swap_dropped <= swap_req && (state != IDLE);
      case (state)
        IDLE: begin
          // a vblank coinciding with the request is too early; wait for the next
          if (swap_req) begin
            state        <= PENDING;
            swap_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (vblank_start) begin
            front_sel    <= ~front_sel;
            frame_count  <= frame_count + 8'd1;
            swap_pending <= 1'b0;
            clr_cnt      <= '0;
            if (clear_on_swap) begin
              state    <= CLEAR;
              clearing <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state    <= IDLE;
            clearing <= 1'b0;
            clr_cnt  <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          swap_pending <= 1'b0;
          clearing     <= 1'b0;
          clr_cnt      <= '0;
        end
      endcase
    end
  end

  // Back RAM drive: clear sweep owns it in CLEAR, otherwise the renderer port.
  always_comb begin
    back_we    = !reset && (wr_fire || (state == CLEAR));
    back_addr  = wr_addr;
    back_wdata = wr_data;
    if (state == CLEAR) begin
      back_addr  = clr_cnt;
      back_wdata = CLEAR_COLOR;
    end
  end

  // Route scan-out to the front RAM and the back port to the other one.
  always_comb begin
    ram0_addr  = rd_addr;
    ram0_wdata = '0;
    ram0_we    = 1'b0;
    ram1_addr  = rd_addr;
    ram1_wdata = '0;
    ram1_we    = 1'b0;
    if (front_sel) begin
      ram0_addr  = back_addr;
      ram0_wdata = back_wdata;
      ram0_we    = back_we;
    end else begin
      ram1_addr  = back_addr;
      ram1_wdata = back_wdata;
      ram1_we    = back_we;
    end
  end

  // Read data comes from whichever RAM was addressed as front last cycle.
  assign rd_data = prev_front ? ram1_rdata : ram0_rdata;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: directed checks of the frame buffer controller with
// two behavioural 1-cycle-latency RAMs and a small PIXELS value.
module tb_frame_buffer_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 9;
  localparam int PIXELS = 16;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              wr_valid, wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              swap_req, vblank_start, clear_on_swap;
  logic [ADDR_W-1:0] ram0_addr, ram1_addr;
  logic [DATA_W-1:0] ram0_wdata, ram1_wdata, ram0_rdata, ram1_rdata;
  logic              ram0_we, ram1_we;
  logic              front_sel, swap_pending, clearing, swap_dropped;
  logic [7:0]        frame_count;
  logic [1:0]        fsm_state;

  frame_buffer_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PIXELS(PIXELS), .CLEAR_COLOR(9'd0)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .swap_req(swap_req), .vblank_start(vblank_start), .clear_on_swap(clear_on_swap),
    .ram0_addr(ram0_addr), .ram0_wdata(ram0_wdata), .ram0_we(ram0_we), .ram0_rdata(ram0_rdata),
    .ram1_addr(ram1_addr), .ram1_wdata(ram1_wdata), .ram1_we(ram1_we), .ram1_rdata(ram1_rdata),
    .front_sel(front_sel), .swap_pending(swap_pending), .clearing(clearing),
    .swap_dropped(swap_dropped), .frame_count(frame_count), .fsm_state(fsm_state)
  );

  // RAM models: preloaded with a known pattern while reset is high
  logic [DATA_W-1:0] mem0 [256];
  logic [DATA_W-1:0] mem1 [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= {1'b0, 8'(i)};
        mem1[i] <= {1'b1, 8'(i)};
      end
    end else begin
      if (ram0_we) mem0[ram0_addr] <= ram0_wdata;
      if (ram1_we) mem1[ram1_addr] <= ram1_wdata;
    end
    ram0_rdata <= mem0[ram0_addr];
    ram1_rdata <= mem1[ram1_addr];
  end

  function automatic logic [DATA_W-1:0] pat(input logic sel, input logic [7:0] a);
    return {sel, a};
  endfunction

  // scoreboard
  int n_cmp = 0;
  int n_bad = 0;
  logic [ADDR_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver helper: advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic       exp_front;
  logic [7:0] exp_fc;
  logic [7:0] a;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    swap_req = 1'b0; vblank_start = 1'b0; clear_on_swap = 1'b0;
    cyc(); cyc();
    #1;
    check("rst_state", 32'(fsm_state), 0);
    check("rst_front", 32'(front_sel), 0);
    check("rst_fc", 32'(frame_count), 0);
    check("rst_pend", 32'(swap_pending), 0);
    check("rst_clr", 32'(clearing), 0);
    check("rst_drop", 32'(swap_dropped), 0);
    check("rst_we0", 32'(ram0_we), 0);
    check("rst_we1", 32'(ram1_we), 0);
    reset = 1'b0; rd_addr = 8'd9;
    #1;
    check("rst_ready", 32'(wr_ready), 1);
    cyc(); #1;
    check("rst_rd_ram0", 32'(rd_data), 32'(pat(1'b0, 8'd9)));

    // renderer write lands on back RAM 1
    rd_addr = 8'd3; wr_valid = 1'b1; wr_addr = 8'd5; wr_data = 9'h1FF;
    #1;
    check("wr_we1", 32'(ram1_we), 1);
    check("wr_addr1", 32'(ram1_addr), 5);
    check("wr_data1", 32'(ram1_wdata), 32'h1FF);
    check("wr_we0", 32'(ram0_we), 0);
    check("wr_addr0", 32'(ram0_addr), 3);
    check("wr_front", 32'(front_sel), 0);
    cyc();
    wr_addr = 8'd200; wr_data = 9'h0AA;
    #1;
    check("wr_oor_addr", 32'(ram1_addr), 200);
    check("wr_oor_we", 32'(ram1_we), 1);
    cyc();
    wr_valid = 1'b0;

    // swap without clear, vblank 10 cycles after request
    swap_req = 1'b1;
    cyc();
    swap_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 9) vblank_start = 1'b1;
      #1;
      check("sw_pend", 32'(swap_pending), 1);
      check("sw_ready0", 32'(wr_ready), 0);
      check("sw_front_hold", 32'(front_sel), 0);
      cyc();
    end
    vblank_start = 1'b0;
    #1;
    check("sw_pend_done", 32'(swap_pending), 0);
    check("sw_front", 32'(front_sel), 1);
    check("sw_fc", 32'(frame_count), 1);
    check("sw_ready", 32'(wr_ready), 1);

    // request and vblank in the same IDLE cycle: no swap yet
    swap_req = 1'b1; vblank_start = 1'b1;
    cyc();
    swap_req = 1'b0; vblank_start = 1'b0;
    #1;
    check("same_pend", 32'(swap_pending), 1);
    check("same_front", 32'(front_sel), 1);
    cyc(); cyc();
    vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0;
    #1;
    check("same_front2", 32'(front_sel), 0);
    check("same_fc", 32'(frame_count), 2);
    check("same_idle", 32'(fsm_state), 0);

    // swap with clear: front becomes 1, RAM 0 swept with zeros
    clear_on_swap = 1'b1; swap_req = 1'b1;
    cyc();
    swap_req = 1'b0; vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0; clear_on_swap = 1'b0; rd_addr = 8'd30;
    for (int i = 0; i < PIXELS; i++) exp_q.push_back(ADDR_W'(i));
    #1;
    check("clr_front", 32'(front_sel), 1);
    check("clr_fc", 32'(frame_count), 3);
    for (int i = 0; i < PIXELS; i++) begin
      #1;
      check("clr_flag", 32'(clearing), 1);
      check("clr_ready", 32'(wr_ready), 0);
      check("clr_we0", 32'(ram0_we), 1);
      check("clr_addr0", 32'(ram0_addr), 32'(exp_q.pop_front()));
      check("clr_wdata0", 32'(ram0_wdata), 0);
      check("clr_we1", 32'(ram1_we), 0);
      check("clr_addr1", 32'(ram1_addr), 30);
      cyc();
    end
    #1;
    check("clr_done", 32'(clearing), 0);
    check("clr_idle", 32'(fsm_state), 0);
    check("clr_ready1", 32'(wr_ready), 1);
    check("clr_we0_off", 32'(ram0_we), 0);
    check("clr_mem0", 32'(mem0[7]), 0);

    // clear of RAM 1, dropped request, then reset at address 7
    clear_on_swap = 1'b1; swap_req = 1'b1;
    cyc();
    swap_req = 1'b0; vblank_start = 1'b1;
    cyc();
    vblank_start = 1'b0; clear_on_swap = 1'b0;
    for (int i = 0; i < 8; i++) begin
      swap_req = 1'b0;
      #1;
      check("drp_addr1", 32'(ram1_addr), 32'(i));
      check("drp_we1", 32'(ram1_we), 1);
      check("drp_front", 32'(front_sel), 0);
      if (i == 3) check("drp_pulse", 32'(swap_dropped), 1);
      if (i == 4) check("drp_pulse_end", 32'(swap_dropped), 0);
      if (i == 2) swap_req = 1'b1;
      if (i == 7) reset = 1'b1;
      cyc();
    end
    reset = 1'b0;
    #1;
    check("rc_front", 32'(front_sel), 0);
    check("rc_we0", 32'(ram0_we), 0);
    check("rc_we1", 32'(ram1_we), 0);
    check("rc_ready", 32'(wr_ready), 1);
    check("rc_state", 32'(fsm_state), 0);
    check("rc_fc", 32'(frame_count), 0);
    cyc(); cyc(); cyc();
    check("rc_no_resume", 32'(clearing), 0);
    check("rc_we1_still", 32'(ram1_we), 0);

    // 256 swaps: frame_count wraps and rd_data follows front with 1-cycle lag
    exp_front = 1'b0;
    exp_fc    = 8'd0;
    for (int s = 0; s < 256; s++) begin
      a = 8'(s);
      rd_addr = a; swap_req = 1'b1;
      cyc();
      swap_req = 1'b0;
      cyc();
      vblank_start = 1'b1;
      #1;
      check("ls_rd_before", 32'(rd_data), 32'(pat(exp_front, a)));
      cyc();
      vblank_start = 1'b0;
      exp_front = ~exp_front;
      exp_fc    = exp_fc + 8'd1;
      #1;
      check("ls_front", 32'(front_sel), 32'(exp_front));
      check("ls_fc", 32'(frame_count), 32'(exp_fc));
      check("ls_rd_lag", 32'(rd_data), 32'(pat(~exp_front, a)));
      if (s == 255) check("fc_wrap", 32'(frame_count), 0);
      cyc();
      check("ls_rd_after", 32'(rd_data), 32'(pat(exp_front, a)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
